// File: rtl/led_pkg.sv
// Shared defaults, step direction type and width helper for the LED up/down counter.
package led_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_TICK_DIV   = 25000000;
  localparam int DEF_HOLD_TICKS = 2;
  localparam int HOLD_W         = 4;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Bits needed to represent 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        bits = i + 1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/led_updown_counter_btn_repeat.sv
// Button front end: two-flop synchroniser, press-edge detection and hold-to-repeat.
module btn_repeat
  import led_pkg::*;
#(
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic tick,
  input  logic other_level,
  output logic level,
  output logic step
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  logic              meta_r;
  logic              sync_r;
  logic              prev_r;
  logic              armed_r;
  logic [1:0]        valid_r;
  logic [HOLD_W-1:0] hold_r;
  logic              active_s;
  logic              repeat_s;

  assign level = sync_r;

  // Either button alone may step; with the other one held nothing happens.
  always_comb begin
    active_s = armed_r & sync_r & ~other_level;
    repeat_s = tick & (hold_r == HOLD_MAX);
    step     = active_s & (~prev_r | repeat_s);
  end

  // A button still held when reset is released must be seen low before it may step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      prev_r  <= 1'b0;
      valid_r <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      meta_r  <= btn;
      sync_r  <= meta_r;
      prev_r  <= sync_r;
      valid_r <= {valid_r[0], 1'b1};
      armed_r <= armed_r | (valid_r[1] & ~sync_r);
    end
  end

  // Ticks spent held, saturating at the repeat threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r <= '0;
    end else if (!active_s) begin
      hold_r <= '0;
    end else if (tick && (hold_r != HOLD_MAX)) begin
      hold_r <= hold_r + 4'd1;
    end else begin
      hold_r <= hold_r;
    end
  end

endmodule

// File: rtl/led_updown_counter.sv
// Two-button up/down counter with tick-based auto-repeat and a blinking LED display.
module led_updown_counter
  import led_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int WRAP       = 1,
  parameter int BLINK      = 1,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_plus,
  input  logic             btn_minus,
  output logic [WIDTH-1:0] led,
  output logic             at_max,
  output logic             at_min
);

  localparam int                TICK_W    = clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(32'd1);
  localparam logic [WIDTH-1:0]  COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  COUNT_MIN = '0;
  localparam logic [WIDTH-1:0]  COUNT_ONE = WIDTH'(32'd1);

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;
  logic              phase_r;
  logic [WIDTH-1:0]  count_r;
  logic [WIDTH-1:0]  count_next_s;
  logic              plus_level_s;
  logic              minus_level_s;
  logic              plus_step_s;
  logic              minus_step_s;
  step_e             dir_s;

  assign tick_s = (tick_cnt_r == TICK_LAST);

  btn_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_plus (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn_plus),
    .tick        (tick_s),
    .other_level (minus_level_s),
    .level       (plus_level_s),
    .step        (plus_step_s)
  );

  btn_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_minus (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn_minus),
    .tick        (tick_s),
    .other_level (plus_level_s),
    .level       (minus_level_s),
    .step        (minus_step_s)
  );

  // Display/repeat time base and blink phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= '0;
      phase_r    <= 1'b0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      phase_r    <= ~phase_r;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
      phase_r    <= phase_r;
    end
  end

  // Step direction; the two step pulses are mutually exclusive by construction.
  always_comb begin
    dir_s = STEP_NONE;
    if (plus_step_s && !minus_step_s) begin
      dir_s = STEP_UP;
    end else if (minus_step_s && !plus_step_s) begin
      dir_s = STEP_DOWN;
    end else begin
      dir_s = STEP_NONE;
    end
  end

  // Next count with wrap or saturation at both ends.
  always_comb begin
    count_next_s = count_r;
    case (dir_s)
      STEP_UP: begin
        if (count_r != COUNT_MAX) begin
          count_next_s = count_r + COUNT_ONE;
        end else if (WRAP != 0) begin
          count_next_s = COUNT_MIN;
        end else begin
          count_next_s = count_r;
        end
      end
      STEP_DOWN: begin
        if (count_r != COUNT_MIN) begin
          count_next_s = count_r - COUNT_ONE;
        end else if (WRAP != 0) begin
          count_next_s = COUNT_MAX;
        end else begin
          count_next_s = count_r;
        end
      end
      default: count_next_s = count_r;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

  // Outputs trail count/phase by one clock; limit flags ignore the blink.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led    <= '0;
      at_max <= 1'b0;
      at_min <= 1'b1;
    end else begin
      if ((BLINK == 0) || !phase_r) begin
        led <= count_r;
      end else begin
        led <= '0;
      end
      at_max <= (count_r == COUNT_MAX);
      at_min <= (count_r == COUNT_MIN);
    end
  end

endmodule

// File: tb/tb_led_updown_counter.sv
// Bench: a wrapping and a saturating instance share stimulus and are checked against a behavioural model.
module tb_led_updown_counter;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int HT = 2;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         btn_plus  = 1'b0;
  logic         btn_minus = 1'b0;
  logic [W-1:0] led_wrap;
  logic [W-1:0] led_sat;
  logic         at_max_wrap;
  logic         at_min_wrap;
  logic         at_max_sat;
  logic         at_min_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_updown_counter #(.WIDTH(W), .TICK_DIV(TD), .WRAP(1), .BLINK(1), .HOLD_TICKS(HT)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .btn_plus(btn_plus), .btn_minus(btn_minus),
    .led(led_wrap), .at_max(at_max_wrap), .at_min(at_min_wrap));

  led_updown_counter #(.WIDTH(W), .TICK_DIV(TD), .WRAP(0), .BLINK(1), .HOLD_TICKS(HT)) dut_sat (
    .clk(clk), .reset_n(reset_n), .btn_plus(btn_plus), .btn_minus(btn_minus),
    .led(led_sat), .at_max(at_max_sat), .at_min(at_min_sat));

  // Behavioural model: edges since reset, tick count, held-tick counts and both counts as integers.
  int         n;
  int         ticks;
  int         cw;
  int         cs;
  int         held[2];
  bit         armed[2];
  bit [2:0]   hist[2];
  logic [3:0] e_led_w, e_led_s;
  logic       e_max_w, e_min_w, e_max_s, e_min_s;

  wire [11:0] obs  = {led_wrap, at_max_wrap, at_min_wrap, led_sat, at_max_sat, at_min_sat};
  wire [11:0] expv = {e_led_w, e_max_w, e_min_w, e_led_s, e_max_s, e_min_s};

  task automatic model_reset();
    n = 0; ticks = 0; cw = 0; cs = 0;
    for (int b = 0; b < 2; b++) begin
      held[b] = 0; armed[b] = 1'b0; hist[b] = 3'b000;
    end
    e_led_w = 4'd0; e_led_s = 4'd0;
    e_max_w = 1'b0; e_max_s = 1'b0;
    e_min_w = 1'b1; e_min_s = 1'b1;
  endtask

  task automatic model_step();
    bit tick;
    bit act;
    bit stp[2];
    int d;
    // hist[b][1] is the synchronised level seen now, hist[b][2] the one a cycle earlier.
    tick = (n % TD) == (TD - 1);
    for (int b = 0; b < 2; b++) begin
      act    = armed[b] && hist[b][1] && !hist[1-b][1];
      stp[b] = act && (!hist[b][2] || (tick && held[b] == HT));
      if (!act) held[b] = 0;
      else held[b] = (held[b] + int'(tick) > HT) ? HT : held[b] + int'(tick);
      if (n >= 2 && !hist[b][1]) armed[b] = 1'b1;
    end
    e_led_w = (ticks % 2 == 0) ? 4'(cw) : 4'd0;
    e_led_s = (ticks % 2 == 0) ? 4'(cs) : 4'd0;
    e_max_w = (cw == 15); e_min_w = (cw == 0);
    e_max_s = (cs == 15); e_min_s = (cs == 0);
    d  = int'(stp[0]) - int'(stp[1]);
    cw = (cw + d + 16) % 16;
    cs = cs + d;
    if (cs < 0) cs = 0;
    else if (cs > 15) cs = 15;
    if (tick) ticks++;
    hist[0] = {hist[0][1:0], btn_plus};
    hist[1] = {hist[1][1:0], btn_minus};
    n++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic test_reset();
    reset_n = 1'b0; btn_plus = 1'b0; btn_minus = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({led_wrap, at_max_wrap, at_min_wrap} !== 6'b0000_0_1) begin
      bad++; $display("FAIL reset_wrap got=%b want=%b", {led_wrap, at_max_wrap, at_min_wrap}, 6'b0000_0_1);
    end
    total++;
    if ({led_sat, at_max_sat, at_min_sat} !== 6'b0000_0_1) begin
      bad++; $display("FAIL reset_sat got=%b want=%b", {led_sat, at_max_sat, at_min_sat}, 6'b0000_0_1);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL reset_cycle got=%h want=%h", obs, expv); end
    end
  endtask

  task automatic test_short_presses();
    int seen3;
    // First pulse: at_min must still be 1 after three edges and drop on the fourth.
    btn_plus = 1'b1;
    repeat (2) @(negedge clk);
    btn_plus = 1'b0;
    @(negedge clk); total++;
    if (at_min_wrap !== 1'b1) begin bad++; $display("FAIL latency_early got=%b want=1", at_min_wrap); end
    @(negedge clk); total++;
    if (at_min_wrap !== 1'b0) begin bad++; $display("FAIL latency_step got=%b want=0", at_min_wrap); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 5; c++) begin
        btn_plus = (c < 2);
        @(negedge clk); total++;
        if (obs !== expv) begin bad++; $display("FAIL short_cycle got=%h want=%h", obs, expv); end
      end
    end
    seen3 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (led_wrap === 4'd3) seen3++;
    end
    total++;
    if (seen3 == 0 || at_min_wrap !== 1'b0) begin
      bad++; $display("FAIL short_three got=%0d/%b want=>0/0", seen3, at_min_wrap);
    end
  endtask

  task automatic test_wrap();
    // Four minus presses from 3, then one plus, then one minus.
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 5; c++) begin
        btn_plus  = (k == 4) && (c < 2);
        btn_minus = (k != 4) && (c < 2);
        @(negedge clk); total++;
        if (obs !== expv) begin bad++; $display("FAIL wrap_cycle got=%h want=%h", obs, expv); end
      end
      if (k == 3 || k == 5) begin
        total++;
        if ({at_max_wrap, at_min_wrap, at_min_sat} !== 3'b101) begin
          bad++; $display("FAIL wrap_under got=%b want=101", {at_max_wrap, at_min_wrap, at_min_sat});
        end
      end else if (k == 4) begin
        total++;
        if ({at_max_wrap, at_min_wrap, at_min_sat} !== 3'b010) begin
          bad++; $display("FAIL wrap_over got=%b want=010", {at_max_wrap, at_min_wrap, at_min_sat});
        end
      end
    end
  endtask

  task automatic test_sat_hold();
    btn_minus = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); total++;
      if (at_min_sat !== 1'b1 || obs !== expv) begin
        bad++; $display("FAIL sat_hold got=%h/%b want=%h/1", obs, at_min_sat, expv);
      end
    end
    btn_minus = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL sat_release got=%h want=%h", obs, expv); end
    end
  endtask

  task automatic test_hold_repeat();
    int blank;
    reset_n = 1'b0; btn_plus = 1'b0; btn_minus = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    blank = 0;
    btn_plus = 1'b1;
    for (int c = 0; c < 46; c++) begin
      if (c == 40) btn_plus = 1'b0;
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL hold_cycle got=%h want=%h", obs, expv); end
      if (led_wrap === 4'd0 && at_min_wrap === 1'b0) blank++;
    end
    total++;
    if (blank == 0) begin bad++; $display("FAIL hold_blink got=%0d want=>0", blank); end
  endtask

  task automatic test_both();
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    btn_plus = 1'b1; btn_minus = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (c == 30) begin btn_plus = 1'b0; btn_minus = 1'b0; end
      @(negedge clk); total++;
      if (at_min_wrap !== 1'b1 || at_min_sat !== 1'b1 || obs !== expv) begin
        bad++; $display("FAIL both_held got=%h want=%h", obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < ((k == 6) ? 10 : 5); c++) begin
        btn_plus = (k == 6) || (c < 2);
        @(negedge clk); total++;
        if (obs !== expv) begin bad++; $display("FAIL mid_build got=%h want=%h", obs, expv); end
      end
    end
    #2 reset_n = 1'b0;
    #1 total++;
    if ({led_wrap, at_max_wrap, at_min_wrap} !== 6'b0000_0_1 || obs !== expv) begin
      bad++; $display("FAIL mid_async got=%h want=%h", obs, expv);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk); total++;
      if (at_min_wrap !== 1'b1 || obs !== expv) begin
        bad++; $display("FAIL mid_stuck got=%h want=%h", obs, expv);
      end
    end
    for (int c = 0; c < 10; c++) begin
      btn_plus = (c >= 5) && (c < 7);
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL mid_repress got=%h want=%h", obs, expv); end
    end
    total++;
    if (at_min_wrap !== 1'b0) begin bad++; $display("FAIL mid_step got=%b want=0", at_min_wrap); end
  endtask

  task automatic test_random();
    int len;
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      btn_plus  = 1'($urandom_range(0, 1));
      btn_minus = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) begin
        @(negedge clk); total++;
        if (obs !== expv) begin bad++; $display("FAIL random_cycle got=%h want=%h", obs, expv); end
      end
    end
    btn_plus = 1'b0; btn_minus = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_short_presses();
    test_wrap();
    test_sat_hold();
    test_hold_repeat();
    test_both();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
